// File: rtl/sr195_arbiter_ctrl_if.sv
// Requester-side handshake bundle for sr195_arbiter_ctrl: two requesters
// packed side by side ({requester1, requester0}).
interface sr195_arbiter_ctrl_if;
  logic [1:0] req;
  logic [3:0] op;
  logic [7:0] wdata;
  logic [3:0] cnt;
  logic [1:0] ack;
  logic [3:0] rdata;
  logic       busy;

  modport master (output req, op, wdata, cnt, input ack, rdata, busy);
  modport slave  (input req, op, wdata, cnt, output ack, rdata, busy);
endinterface

// File: rtl/sr195_arbiter_ctrl.sv
// Round-robin two-port sequencer driving every control input of a 4-bit
// sr_74195 shift register (load, serial shift-in, rotate, read).
module sr195_arbiter_ctrl (
  input  logic                       CP,
  input  logic                       MR_n,
  sr195_arbiter_ctrl_if.slave        bus,
  output logic                       sr_PE_n,
  output logic                       sr_J,
  output logic                       sr_K_n,
  output logic [3:0]                 sr_D,
  input  logic [3:0]                 sr_Q
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_LOAD   = 2'd0;
  localparam logic [1:0] OP_ROTATE = 2'd2;
  localparam logic [1:0] OP_READ   = 2'd3;

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic       winner_q, winner_d;
  logic [1:0] k_q, k_d;
  logic [1:0] op_q, op_d;
  logic [3:0] wdata_q, wdata_d;
  logic [1:0] cnt_q, cnt_d;

  logic       grant;
  logic [1:0] grant_op;
  logic       shift_bit;

  // Only on contention does the pointer matter: the one not served last wins.
  always_comb begin
    grant    = (bus.req == 2'b11) ? ~last_q : bus.req[1];
    grant_op = grant ? bus.op[3:2] : bus.op[1:0];
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    winner_d = winner_q;
    k_d      = k_q;
    op_d     = op_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          winner_d = grant;
          last_d   = grant;
          op_d     = grant_op;
          wdata_d  = grant ? bus.wdata[7:4] : bus.wdata[3:0];
          cnt_d    = grant ? bus.cnt[3:2] : bus.cnt[1:0];
          k_d      = 2'd0;
          state_d  = (grant_op == OP_READ) ? ST_DONE : ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_q == OP_LOAD || k_q == cnt_q) begin
          state_d = ST_DONE;
          k_d     = 2'd0;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CP or negedge MR_n) begin
    if (!MR_n) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      winner_q <= 1'b0;
      k_q      <= 2'd0;
      op_q     <= OP_LOAD;
      wdata_q  <= 4'd0;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      winner_q <= winner_d;
      k_q      <= k_d;
      op_q     <= op_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // The register shifts on every edge unless loaded, so outside EXEC it is
  // held by reloading its own outputs.
  always_comb begin
    shift_bit = (op_q == OP_ROTATE) ? sr_Q[3] : wdata_q[k_q];
    sr_PE_n   = 1'b0;
    sr_D      = sr_Q;
    sr_J      = 1'b0;
    sr_K_n    = 1'b1;
    if (state_q == ST_EXEC) begin
      if (op_q == OP_LOAD) begin
        sr_D = wdata_q;
      end else begin
        sr_PE_n = 1'b1;
        sr_J    = shift_bit;
        sr_K_n  = ~shift_bit;
      end
    end
  end

  assign bus.ack   = (state_q == ST_DONE) ? (winner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rdata = (|bus.ack) ? sr_Q : 4'd0;
  assign bus.busy  = (state_q != ST_IDLE);

endmodule
